// File: rtl/line_pkg.sv
// Shared definitions for the line-sensor front end and the speed controller.
package line_pkg;

    // Width of the published line count.
    localparam int unsigned LIN_W = 32;

    // Slow-zone line indices along the track, used by the speed controller.
    localparam int unsigned SLOW_LINE_A = 3;
    localparam int unsigned SLOW_LINE_B = 9;

    // Line-tracking FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        WHITE = 3'd2,
        BLACK = 3'd3,
        LOCK  = 3'd4
    } line_state_e;

endpackage : line_pkg

// File: rtl/line_debounce.sv
// Two-flop synchroniser plus run-length debouncer for the raw IR sensor.
// level follows raw only after DEBOUNCE_CYC consecutive disagreeing samples.
module line_debounce
    import line_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter bit          BLACK_LEVEL  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             blk_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    assign blk_s = (sync2_q == BLACK_LEVEL);
    assign level = level_q;

    // Count consecutive samples that disagree with the accepted level; flip on the last one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (blk_s != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter and accepted level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule : line_debounce

// File: rtl/line_counter.sv
// Black-line counter feeding the wheel-speed controller.
// Debounces the IR sensor, counts white-to-black crossings and blanks edges
// for a lockout window after each line's trailing edge.
// Optional macro LINE_CNT_WRAP_EN: count modulo MAX_LINES and strobe lap_pulse
// on wrap; without it the count saturates at MAX_LINES and lap_pulse is 0.
module line_counter
    import line_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter int unsigned LOCKOUT_CYC  = 20000000,
    parameter int unsigned MAX_LINES    = 12,
    parameter bit          BLACK_LEVEL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             ir_raw,
    output logic [LIN_W-1:0] lin,
    output logic             line_pulse,
    output logic             lap_pulse,
    output logic             on_black
);

    localparam int unsigned LOCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    line_state_e       state_q;
    logic [LIN_W-1:0]  lin_q;
    logic [LOCK_W-1:0] lock_q;
    logic              line_pulse_q;
    logic              on_black_w;

    line_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .BLACK_LEVEL  (BLACK_LEVEL)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (ir_raw),
        .level (on_black_w)
    );

    assign lin        = lin_q;
    assign line_pulse = line_pulse_q;
    assign on_black   = on_black_w;

`ifdef LINE_CNT_WRAP_EN
    logic lap_pulse_q;
    assign lap_pulse = lap_pulse_q;
`else
    assign lap_pulse = 1'b0;
`endif

    // Line-tracking FSM with lockout timer and registered count/strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lin_q        <= '0;
            lock_q       <= '0;
            line_pulse_q <= 1'b0;
`ifdef LINE_CNT_WRAP_EN
            lap_pulse_q  <= 1'b0;
`endif
        end else begin
            line_pulse_q <= 1'b0;
`ifdef LINE_CNT_WRAP_EN
            lap_pulse_q  <= 1'b0;
`endif
            if (clr) begin
                // Clear wins over any increment in the same cycle.
                lin_q   <= '0;
                lock_q  <= '0;
                state_q <= start ? ARM : IDLE;
            end else if (!start) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                    end
                    ARM: begin
                        // Require white first so a line under the car is not counted.
                        if (!on_black_w) begin
                            state_q <= WHITE;
                        end
                    end
                    WHITE: begin
                        if (on_black_w) begin
                            state_q <= BLACK;
`ifdef LINE_CNT_WRAP_EN
                            line_pulse_q <= 1'b1;
                            if (lin_q == LIN_W'(MAX_LINES - 1)) begin
                                lin_q       <= '0;
                                lap_pulse_q <= 1'b1;
                            end else begin
                                lin_q <= lin_q + LIN_W'(1);
                            end
`else
                            if (lin_q < LIN_W'(MAX_LINES)) begin
                                lin_q        <= lin_q + LIN_W'(1);
                                line_pulse_q <= 1'b1;
                            end
`endif
                        end
                    end
                    BLACK: begin
                        if (!on_black_w) begin
                            lock_q  <= LOCK_W'(LOCKOUT_CYC - 1);
                            state_q <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (lock_q == '0) begin
                            state_q <= ARM;
                        end else begin
                            lock_q <= lock_q - LOCK_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : line_counter

// File: tb/tb_line_counter.sv
// Self-checking bench for line_counter: directed scenarios plus random sensor
// activity, all compared against a cycle-level behavioural model.
module tb_line_counter;

    localparam int unsigned DEB   = 4;
    localparam int unsigned LOCKC = 10;
    localparam int unsigned MAXL  = 12;
    localparam bit          BLACK = 1'b1;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        clr    = 1'b0;
    logic        ir_raw = 1'b0;
    logic [31:0] lin;
    logic        line_pulse;
    logic        lap_pulse;
    logic        on_black;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses_seen = 0;
    int laps_seen = 0;

    line_counter #(
        .DEBOUNCE_CYC (DEB),
        .LOCKOUT_CYC  (LOCKC),
        .MAX_LINES    (MAXL),
        .BLACK_LEVEL  (BLACK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clr        (clr),
        .ir_raw     (ir_raw),
        .lin        (lin),
        .line_pulse (line_pulse),
        .lap_pulse  (lap_pulse),
        .on_black   (on_black)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int     m_lin;
    bit     m_lp;
    bit     m_lap;
    bit     m_ob;
    bit     m_en;        // counting enabled (past the start-up cycle)
    bit     m_armed;     // white has been seen, next black is a line
    bit     m_inline;    // currently on a counted (or saturated) line
    longint m_release;   // cycle at which lockout ends, -1 when none
    longint m_cyc;
    bit     raw_q[$];    // raw samples still in the synchroniser
    bit     blk_q[$];    // most recent synchronised black samples

    task automatic model_reset();
        m_lin = 0; m_lp = 0; m_lap = 0; m_ob = 0;
        m_en = 0; m_armed = 0; m_inline = 0; m_release = -1; m_cyc = 0;
        raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
        blk_q.delete();
    endtask

    task automatic model_step();
        bit ob_old;
        bit blk;
        bit flip;
        m_cyc++;
        ob_old = m_ob;
        m_lp = 0;
        m_lap = 0;
        // Sensor level is accepted once the last DEB synchronised samples all disagree.
        blk = (raw_q[0] == BLACK);
        raw_q.push_back(ir_raw);
        void'(raw_q.pop_front());
        blk_q.push_back(blk);
        if (blk_q.size() > DEB) void'(blk_q.pop_front());
        flip = (blk_q.size() == DEB);
        foreach (blk_q[i]) if (blk_q[i] == m_ob) flip = 0;
        if (flip) m_ob = !m_ob;
        // Counting rules, using the level as it was before this edge.
        if (clr) begin
            m_lin = 0; m_en = start; m_armed = 0; m_inline = 0; m_release = -1;
        end else if (!start) begin
            m_en = 0;
        end else if (!m_en) begin
            m_en = 1; m_armed = 0; m_inline = 0; m_release = -1;
        end else if (m_release >= 0) begin
            if (m_cyc == m_release) m_release = -1;
        end else if (m_inline) begin
            if (!ob_old) begin
                m_inline = 0;
                m_release = m_cyc + LOCKC;
            end
        end else if (!m_armed) begin
            if (!ob_old) m_armed = 1;
        end else if (ob_old) begin
            m_armed = 0;
            m_inline = 1;
`ifdef LINE_CNT_WRAP_EN
            m_lin = (m_lin + 1) % MAXL;
            m_lp = 1;
            m_lap = (m_lin == 0);
`else
            if (m_lin < MAXL) begin
                m_lin = m_lin + 1;
                m_lp = 1;
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check_eq("cyc_lin", lin, 32'(m_lin));
            check_eq("cyc_line_pulse", 32'(line_pulse), 32'(m_lp));
            check_eq("cyc_lap_pulse", 32'(lap_pulse), 32'(m_lap));
            check_eq("cyc_on_black", 32'(on_black), 32'(m_ob));
            if (line_pulse) pulses_seen++;
            if (lap_pulse) laps_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raw_pulse(input int hi, input int lo);
        ir_raw = 1'b1;
        step(hi);
        ir_raw = 1'b0;
        step(lo);
    endtask

    int p0;
    int l0;

    initial begin
        // Reset values.
        step(3);
        check_eq("rst_lin", lin, 0);
        check_eq("rst_line_pulse", 32'(line_pulse), 0);
        check_eq("rst_lap_pulse", 32'(lap_pulse), 0);
        check_eq("rst_on_black", 32'(on_black), 0);
        rst_n = 1'b1;

        // Glitch shorter than the debounce window is rejected.
        start = 1'b1;
        step(4);
        raw_pulse(3, 10);
        check_eq("glitch_on_black", 32'(on_black), 0);
        check_eq("glitch_lin", lin, 0);
        check_eq("glitch_pulses", 32'(pulses_seen), 0);

        // Single line: debounce latency and one-cycle count strobe.
        p0 = pulses_seen;
        ir_raw = 1'b1;
        step(5);
        check_eq("single_ob_early", 32'(on_black), 0);
        step(1);
        check_eq("single_ob_rise", 32'(on_black), 1);
        check_eq("single_lp_early", 32'(line_pulse), 0);
        step(1);
        check_eq("single_lp", 32'(line_pulse), 1);
        check_eq("single_lin", lin, 1);
        step(13);
        ir_raw = 1'b0;
        step(5);
        check_eq("single_ob_hold", 32'(on_black), 1);
        step(1);
        check_eq("single_ob_fall", 32'(on_black), 0);

        // Second black inside the lockout is ignored; after lockout it counts.
        step(3);
        raw_pulse(8, 20);
        check_eq("lockout_lin", lin, 1);
        step(20);
        raw_pulse(8, 20);
        check_eq("after_lockout_lin", lin, 2);
        check_eq("after_lockout_pulses", 32'(pulses_seen - p0), 2);

        // Starting while on black does not count until white then black are seen.
        start = 1'b0;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_eq("clr_idle_lin", lin, 0);
        ir_raw = 1'b1;
        step(20);
        start = 1'b1;
        step(20);
        check_eq("startblack_lin0", lin, 0);
        ir_raw = 1'b0;
        step(20);
        check_eq("startblack_lin_white", lin, 0);
        raw_pulse(20, 25);
        check_eq("startblack_lin1", lin, 1);

        // Saturation / wrap over 13 separated lines.
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(10);
        p0 = pulses_seen;
        l0 = laps_seen;
        for (int i = 0; i < 12; i++) raw_pulse(10, 25);
`ifdef LINE_CNT_WRAP_EN
        check_eq("wrap12_lin", lin, 0);
        check_eq("wrap12_laps", 32'(laps_seen - l0), 1);
`else
        check_eq("sat12_lin", lin, 12);
        check_eq("sat12_laps", 32'(laps_seen - l0), 0);
`endif
        raw_pulse(10, 25);
`ifdef LINE_CNT_WRAP_EN
        check_eq("wrap13_lin", lin, 1);
        check_eq("wrap13_pulses", 32'(pulses_seen - p0), 13);
`else
        check_eq("sat13_lin", lin, 12);
        check_eq("sat13_pulses", 32'(pulses_seen - p0), 12);
`endif

        // clr in the same cycle as a qualifying rise wins.
        ir_raw = 1'b1;
        step(6);
        check_eq("clrrace_ob", 32'(on_black), 1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_eq("clrrace_lin", lin, 0);
        check_eq("clrrace_lp", 32'(line_pulse), 0);
        step(14);
        ir_raw = 1'b0;
        step(10);
        raw_pulse(10, 9);
        check_eq("prelock_lin", lin, 1);

        // Async reset while the lockout timer runs.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstlock_lin", lin, 0);
        check_eq("rstlock_lp", 32'(line_pulse), 0);
        check_eq("rstlock_lap", 32'(lap_pulse), 0);
        check_eq("rstlock_ob", 32'(on_black), 0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Random sensor activity with occasional clear and start toggles.
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            ir_raw = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 25));
            for (int c = 0; c < len; c++) begin
                clr = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 299) == 0) start = !start;
                step(1);
            end
            clr = 1'b0;
            if (seg % 50 == 49) start = 1'b1;
        end
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_line_counter

// File: doc/line_counter.md
Name: line_counter

Overview:
- Upstream stage of the wheel-speed controller. Turns the raw IR line-sensor level into the 32-bit black-line count `lin` that the speed controller uses to pick full or reduced speed.
- Signal path: synchronises the sensor, debounces it, then counts each confirmed white-to-black crossing.
- A lockout window after each line prevents double counts on wide or ragged tape.

Parameters:
- DEBOUNCE_CYC, 100000, consecutive stable cycles needed to accept a sensor level change (1 ms at 100 MHz).
- LOCKOUT_CYC, 20000000, cycles after a line's trailing edge during which edges are ignored (200 ms).
- MAX_LINES, 12, upper bound of the count; 32-bit unsigned.
- BLACK_LEVEL, 1, raw sensor level meaning "on black".

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; 1 = counting enabled.
- clr  in  1  synchronous clear of the count, single-cycle.
- ir_raw  in  1  raw sensor, asynchronous to clk.
- lin  out  32  confirmed line count, feeds the speed controller.
- line_pulse  out  1  one-cycle strobe on each counted line.
- lap_pulse  out  1  one-cycle strobe on lap wrap (only with LINE_CNT_WRAP_EN, else constant 0).
- on_black  out  1  debounced sensor state.

Behaviour:
- Reset (rst_n=0, async): lin=0, line_pulse=0, lap_pulse=0, on_black=0, sync flops=0, debounce and lockout counters=0, FSM=IDLE.
- Synchroniser:
  - 2-flop.
  - blk_s = (sync_out == BLACK_LEVEL).
- Debounce:
  - When blk_s != on_black, cnt increments; when it equals, cnt clears.
  - on_black toggles on the cycle cnt reaches DEBOUNCE_CYC-1, and cnt clears.
  - Any glitch shorter than DEBOUNCE_CYC cycles is fully rejected.
  - Latency from a raw edge to an on_black edge = 2 + DEBOUNCE_CYC cycles.
- FSM states: IDLE, ARM, WHITE, BLACK, LOCK.
  - IDLE: counting disabled. If start=1, go to ARM next cycle.
  - ARM: wait for on_black=0, then go to WHITE. This prevents counting a line the car is already sitting on.
  - WHITE: when on_black rises, count the line, assert line_pulse for that cycle, and go to BLACK.
  - BLACK: when on_black falls, load the lockout counter with LOCKOUT_CYC-1 and go to LOCK.
  - LOCK: decrement the lockout counter. At 0, go to ARM. Sensor edges are ignored while in LOCK.
  - start=0 in any state: go to IDLE next cycle; lin is held, not cleared.
- Counting (no macro):
  - If lin < MAX_LINES, increment lin by 1.
  - At lin == MAX_LINES, lin holds and line_pulse is NOT asserted; the FSM still goes to BLACK.
- lin is registered. It updates on the same edge as line_pulse, which is 1 cycle after the on_black rise.
- clr:
  - lin=0, lockout counter=0.
  - FSM goes to ARM if start=1, else IDLE.
  - line_pulse and lap_pulse are forced to 0.
  - clr beats a simultaneous increment.
  - clr does not touch the debouncer.
- Reset mid-LOCK or mid-debounce: everything returns to reset values immediately. No residual counts.

Optional Feature:
- Macro: LINE_CNT_WRAP_EN.
- Defined (lap mode):
  - lin counts modulo MAX_LINES.
  - An increment from MAX_LINES-1 sets lin=0 and asserts lap_pulse together with line_pulse for one cycle.
  - lin never equals MAX_LINES.
- Undefined: saturating behaviour as above, and lap_pulse is tied to 0.

Decomposition:
- Shared package line_pkg:
  - FSM state enum: IDLE, ARM, WHITE, BLACK, LOCK.
  - LIN_W=32.
  - Track segment constants (3, 9 = slow-zone line indices), shared with the speed controller.
- One natural sub-module, line_debounce:
  - Contains the 2-flop sync and the debounce counter.
  - Params: DEBOUNCE_CYC, BLACK_LEVEL.
  - Ports: clk, rst_n, raw in, level out.
- line_counter holds the FSM, lockout timer and count.

Test Plan (bench uses DEBOUNCE_CYC=4, LOCKOUT_CYC=10, MAX_LINES=12):
- Glitch reject: start=1; ir_raw pulses high for 3 cycles -> on_black stays 0, lin=0, no line_pulse.
- Single line: ir_raw high for 20 cycles, then low -> on_black rises 6 cycles after the raw edge; line_pulse occurs once, 1 cycle later; lin=1.
- Lockout: after the line ends, a second 8-cycle black pulse starts 3 cycles after on_black falls -> ignored, lin stays 1. The same pulse after lockout expires -> lin=2.
- Start on black: ir_raw=1 before start rises -> no count until white is seen and a new black appears; then lin=1.
- Saturation / wrap: 13 separated lines.
  - Without macro: lin ends at 12 and the 13th line gives no line_pulse.
  - With LINE_CNT_WRAP_EN: the 12th line sets lin=0 with lap_pulse=1; the 13th sets lin=1.
- clr vs increment: assert clr in the same cycle as a qualifying rise -> lin=0, line_pulse=0. Async rst_n low during LOCK -> all outputs 0 immediately.
